// File: rtl/clb_cfg_pkg.sv
// Shared types and constants for the CLB column configuration loader:
// command encoding, per-column field layout, reset value and FSM states.
package clb_cfg_pkg;

  localparam int CFG_BITS = 28;
  localparam logic [CFG_BITS-1:0] RST_CFG = 28'h000000F;

  // Column word layout, LSB first; bypass[3] controls cell 0
  localparam int BYPASS_LSB = 0;
  localparam int BYPASS_W   = 4;
  localparam int SEL_W      = 2;
  localparam int SEL0_0_LSB = 4;
  localparam int SEL1_0_LSB = 6;
  localparam int SEL0_1_LSB = 8;
  localparam int SEL1_1_LSB = 10;
  localparam int SEL0_2_LSB = 12;
  localparam int SEL1_2_LSB = 14;
  localparam int SEL0_3_LSB = 16;
  localparam int SEL1_3_LSB = 18;
  localparam int SELOP0_LSB = 20;
  localparam int SELOP1_LSB = 22;
  localparam int SELOP2_LSB = 24;
  localparam int SELOP3_LSB = 26;

  typedef enum logic [1:0] {
    CMD_WRITE  = 2'b00,
    CMD_COMMIT = 2'b01,
    CMD_CLEAR  = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

endpackage

// File: rtl/clb_cfg_regbank.sv
// One CLB column's shadow/active register pair. Shadow is written or cleared
// by the loader; active copies shadow on commit and drives the column.
module clb_cfg_regbank
  import clb_cfg_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CFG_BITS-1:0] wr_data,
  input  logic                clr,
  input  logic                commit,
  output logic [CFG_BITS-1:0] active
);

  logic [CFG_BITS-1:0] shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= RST_CFG;
      active <= RST_CFG;
    end else begin
      if (clr)
        shadow <= RST_CFG;
      else if (wr_en)
        shadow <= wr_data;
      if (commit)
        active <= shadow;
    end
  end

endmodule

// File: rtl/clb_column_cfg_loader.sv
// Byte-stream configuration loader for the CLB column array.
// Optional build macro CLB_CFG_CHECKSUM_EN adds an XOR checksum byte to WRITE frames.
//
// state      | meaning
// ST_IDLE    | waiting for a header byte
// ST_PAYLOAD | collecting WRITE payload (and checksum) bytes, cnt_q = byte index
// ST_COMMIT  | one cycle after commit: cfg_updated high, cfg_ready low
module clb_column_cfg_loader
  import clb_cfg_pkg::*;
#(
  parameter int NUM_COLS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_valid,
  input  logic [7:0]                   cfg_data,
  output logic                         cfg_ready,
  output logic [NUM_COLS*CFG_BITS-1:0] cfg_out,
  output logic                         cfg_updated,
  output logic                         err
);

`ifdef CLB_CFG_CHECKSUM_EN
  localparam logic [2:0] FRAME_LAST = 3'd4;
`else
  localparam logic [2:0] FRAME_LAST = 3'd3;
`endif

  state_e              state_q, state_d;
  logic [2:0]          cnt_q;
  logic [5:0]          col_q;
  logic [CFG_BITS-1:0] word_q, word_full;
  logic [7:0]          csum_q;
  logic                err_q;
  logic                accept, col_ok, frame_ok, frame_done;
  logic                do_commit, do_clear, rsvd_hit, wr_hit;
  cmd_e                hdr_cmd;

  assign cfg_ready   = !reset && (state_q != ST_COMMIT);
  assign accept      = cfg_valid && cfg_ready;
  assign hdr_cmd     = cmd_e'(cfg_data[7:6]);
  assign col_ok      = {1'b0, col_q} < 7'(NUM_COLS);
  assign cfg_updated = (state_q == ST_COMMIT);
  assign err         = err_q;

`ifdef CLB_CFG_CHECKSUM_EN
  assign frame_ok = (csum_q == cfg_data);
`else
  assign frame_ok = 1'b1;
`endif

  assign wr_hit   = frame_done && col_ok && frame_ok;
  assign rsvd_hit = (state_q == ST_IDLE) && accept && (hdr_cmd == CMD_RSVD);

  // Last data byte contributes only its low nibble (bits [31:28] are dropped)
  always_comb begin
    word_full = word_q;
    if (cnt_q == 3'd3)
      word_full[27:24] = cfg_data[3:0];
  end

  always_comb begin
    state_d    = state_q;
    do_commit  = 1'b0;
    do_clear   = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (hdr_cmd)
            CMD_WRITE:  state_d = ST_PAYLOAD;
            CMD_COMMIT: begin
              do_commit = 1'b1;
              state_d   = ST_COMMIT;
            end
            CMD_CLEAR:  do_clear = 1'b1;
            default:    ;
          endcase
        end
      end
      ST_PAYLOAD: begin
        if (accept && (cnt_q == FRAME_LAST)) begin
          frame_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (frame_done && !(col_ok && frame_ok)) || rsvd_hit;
      if (state_q == ST_IDLE && accept) begin
        col_q  <= cfg_data[5:0];
        cnt_q  <= '0;
        csum_q <= cfg_data;
      end else if (state_q == ST_PAYLOAD && accept) begin
        cnt_q  <= cnt_q + 3'd1;
        csum_q <= csum_q ^ cfg_data;
        unique case (cnt_q)
          3'd0:    word_q[7:0]   <= cfg_data;
          3'd1:    word_q[15:8]  <= cfg_data;
          3'd2:    word_q[23:16] <= cfg_data;
          3'd3:    word_q[27:24] <= cfg_data[3:0];
          default: ;
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_COLS; k++) begin : g_col
    clb_cfg_regbank u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_hit && (col_q == 6'(k))),
      .wr_data (word_full),
      .clr     (do_clear),
      .commit  (do_commit),
      .active  (cfg_out[k*CFG_BITS +: CFG_BITS])
    );
  end

endmodule

// File: tb/tb_clb_column_cfg_loader.sv
// Directed self-checking bench for clb_column_cfg_loader (NUM_COLS = 4).
// Build with CLB_CFG_CHECKSUM_EN to exercise checksum frames.
module tb_clb_column_cfg_loader;

  localparam int NC = 4;
  localparam logic [27:0] RST = 28'h000000F;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cfg_valid = 1'b0;
  logic [7:0]     cfg_data = 8'h00;
  logic           cfg_ready;
  logic [NC*28-1:0] cfg_out;
  logic           cfg_updated;
  logic           err;

  int n_checks = 0;
  int n_errors = 0;

  clb_column_cfg_loader #(.NUM_COLS(NC)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_data    (cfg_data),
    .cfg_ready   (cfg_ready),
    .cfg_out     (cfg_out),
    .cfg_updated (cfg_updated),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [NC*28-1:0] pack(input logic [27:0] c0, input logic [27:0] c1,
                                            input logic [27:0] c2, input logic [27:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents a byte from a falling edge, holds it until accepted, returns 1ns after the accepting edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = b;
    n = 0;
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) chk("accept_timeout", 128'(cfg_ready), 128'(1));
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send_write(input logic [5:0] col, input logic [31:0] w, input bit bad);
    logic [7:0] cs;
    logic [7:0] b;
    cs = {2'b00, col};
    send_byte(cs);
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      cs = cs ^ b;
      send_byte(b);
    end
`ifdef CLB_CFG_CHECKSUM_EN
    send_byte(bad ? (cs ^ 8'h01) : cs);
`else
    if (bad) $display("note: corrupt checksum requested without checksum build");
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 128'(cfg_ready), 128'(0));
    chk("rst_cfg_out", 128'(cfg_out), 128'(pack(RST, RST, RST, RST)));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_updated", 128'(cfg_updated), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    next_cycle();
    chk("ready_after_rst", 128'(cfg_ready), 128'(1));

    // out-of-range column: payload consumed, err pulse, commit leaves reset values
    send_write(6'd5, 32'hDDCCBBAA, 1'b0);
    chk("badcol_err", 128'(err), 128'(1));
    next_cycle();
    chk("badcol_err_clear", 128'(err), 128'(0));
    send_byte(8'h40);
    chk("badcol_commit_out", 128'(cfg_out), 128'(pack(RST, RST, RST, RST)));

    // write col1, not visible until commit
    send_write(6'd1, 32'h0BCD1234, 1'b0);
    chk("wr1_no_err", 128'(err), 128'(0));
    chk("wr1_out_unchanged", 128'(cfg_out), 128'(pack(RST, RST, RST, RST)));
    send_byte(8'h40);
    chk("commit1_out", 128'(cfg_out), 128'(pack(RST, 28'hBCD1234, RST, RST)));
    chk("commit1_updated", 128'(cfg_updated), 128'(1));
    chk("commit1_ready_low", 128'(cfg_ready), 128'(0));
    next_cycle();
    chk("commit1_updated_end", 128'(cfg_updated), 128'(0));
    chk("commit1_ready_back", 128'(cfg_ready), 128'(1));

    // reserved header, following byte parsed as a header (commit, col field ignored)
    send_byte(8'hC0);
    chk("rsvd_err", 128'(err), 128'(1));
    send_byte(8'h42);
    chk("rsvd_next_is_hdr", 128'(cfg_updated), 128'(1));
    chk("rsvd_err_end", 128'(err), 128'(0));

    // clear touches only shadows
    send_byte(8'h80);
    chk("clear_active_kept", 128'(cfg_out), 128'(pack(RST, 28'hBCD1234, RST, RST)));
    send_byte(8'h40);
    chk("clear_commit", 128'(cfg_out), 128'(pack(RST, RST, RST, RST)));

    // two columns including the last one; upper nibble of word ignored
    send_write(6'd3, 32'hF2345678, 1'b0);
    send_write(6'd0, 32'h00ABCDEF, 1'b0);
    send_byte(8'h40);
    chk("multi_commit", 128'(cfg_out), 128'(pack(28'h0ABCDEF, RST, RST, 28'h2345678)));

    // gapped frame to col0, reset after its third payload byte
    send_byte(8'h00);
    @(negedge clk);
    send_byte(8'h11);
    @(negedge clk);
    send_byte(8'h22);
    @(negedge clk);
    send_byte(8'h33);
    @(negedge clk);
    reset = 1'b1;
    next_cycle();
    chk("midrst_out", 128'(cfg_out), 128'(pack(RST, RST, RST, RST)));
    chk("midrst_ready", 128'(cfg_ready), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    send_byte(8'h40);
    chk("midrst_shadow_clean", 128'(cfg_out), 128'(pack(RST, RST, RST, RST)));
    send_write(6'd0, 32'h01234567, 1'b0);
    send_byte(8'h40);
    chk("midrst_reload", 128'(cfg_out), 128'(pack(28'h1234567, RST, RST, RST)));

`ifdef CLB_CFG_CHECKSUM_EN
    send_write(6'd2, 32'h0C0FFEE5, 1'b0);
    chk("cs_good_err", 128'(err), 128'(0));
    send_byte(8'h40);
    chk("cs_good_commit", 128'(cfg_out), 128'(pack(28'h1234567, RST, 28'hC0FFEE5, RST)));
    send_write(6'd2, 32'h05555555, 1'b1);
    chk("cs_bad_err", 128'(err), 128'(1));
    send_byte(8'h40);
    chk("cs_bad_commit", 128'(cfg_out), 128'(pack(28'h1234567, RST, 28'hC0FFEE5, RST)));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
